// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_pkg;

   localparam int BYTE_W = 8;

   // Occupancy counters need one extra bit so that "full" (== depth) is representable.
   function automatic int occ_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Byte storage for the RX FIFO: one write port, one registered read port.
// The read register is cleared on reset; the array itself is never cleared.
module uart_fifo_ram
   import uart_pkg::*;
#(
   parameter int g_Depth = 16
) (
   input  logic                       i_Clk,
   input  logic                       i_Rst,
   input  logic                       i_Wr_En,
   input  logic [$clog2(g_Depth)-1:0] i_Wr_Addr,
   input  logic [BYTE_W-1:0]          i_Wr_Data,
   input  logic                       i_Rd_En,
   input  logic [$clog2(g_Depth)-1:0] i_Rd_Addr,
   output logic [BYTE_W-1:0]          o_Rd_Data
);

   logic [BYTE_W-1:0] mem_q [g_Depth];
   logic [BYTE_W-1:0] rd_data_q;

   always_ff @(posedge i_Clk) begin
      if (i_Wr_En) mem_q[i_Wr_Addr] <= i_Wr_Data;
   end

   // Read-before-write: a read and a write to the same slot return the old byte.
   always_ff @(posedge i_Clk) begin
      if (i_Rst)        rd_data_q <= '0;
      else if (i_Rd_En) rd_data_q <= mem_q[i_Rd_Addr];
   end

   assign o_Rd_Data = rd_data_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between the UART receiver and its consumer, with registered status flags.
// Optional sticky overflow flag: define UART_RX_FIFO_OVF_EN.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int g_Depth       = 16,
   parameter int g_Almost_Full = 12
) (
   input  logic                            i_Clk,
   input  logic                            i_Rst,
   input  logic                            i_RX_DV,
   input  logic [BYTE_W-1:0]               i_RX_Byte,
   input  logic                            i_Rd_En,
   output logic [BYTE_W-1:0]               o_Rd_Byte,
   output logic                            o_Rd_DV,
   output logic                            o_Empty,
   output logic                            o_Full,
   output logic                            o_Almost_Full,
   output logic [occ_width(g_Depth)-1:0]   o_Count
`ifdef UART_RX_FIFO_OVF_EN
   ,
   input  logic                            i_Ovf_Clr,
   output logic                            o_Overflow
`endif
);

   localparam int AW = $clog2(g_Depth);
   localparam int CW = occ_width(g_Depth);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty_q, full_q, afull_q, rd_dv_q;
   logic          wr_acc, rd_acc;

   // A full FIFO still takes a write when the head leaves in the same cycle.
   always_comb begin
      rd_acc   = i_Rd_En && !empty_q;
      wr_acc   = i_RX_DV && (!full_q || rd_acc);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         rd_dv_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= (count_d == '0);
         full_q   <= (count_d == CW'(g_Depth));
         afull_q  <= (count_d >= CW'(g_Almost_Full));
         rd_dv_q  <= rd_acc;
      end
   end

   uart_fifo_ram #(
      .g_Depth (g_Depth)
   ) u_ram (
      .i_Clk     (i_Clk),
      .i_Rst     (i_Rst),
      .i_Wr_En   (wr_acc && !i_Rst),
      .i_Wr_Addr (wr_ptr_q),
      .i_Wr_Data (i_RX_Byte),
      .i_Rd_En   (rd_acc),
      .i_Rd_Addr (rd_ptr_q),
      .o_Rd_Data (o_Rd_Byte)
   );

   assign o_Rd_DV       = rd_dv_q;
   assign o_Empty       = empty_q;
   assign o_Full        = full_q;
   assign o_Almost_Full = afull_q;
   assign o_Count       = count_q;

`ifdef UART_RX_FIFO_OVF_EN
   logic ovf_q;

   // A dropped write wins over a same-cycle clear.
   always_ff @(posedge i_Clk) begin
      if (i_Rst)                    ovf_q <= 1'b0;
      else if (i_RX_DV && !wr_acc)  ovf_q <= 1'b1;
      else if (i_Ovf_Clr)           ovf_q <= 1'b0;
   end

   assign o_Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int D  = 16;
   localparam int AF = 12;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_dv = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       rd_en = 1'b0;
   logic [7:0] rd_byte;
   logic       rd_dv, empty, full, afull;
   logic [4:0] count;
`ifdef UART_RX_FIFO_OVF_EN
   logic       ovf_clr = 1'b0;
   logic       overflow;
   bit         exp_ovf;
`endif

   int         n_pass = 0;
   int         n_tot  = 0;
   logic [7:0] q[$];
   logic [7:0] exp_byte;
   bit         exp_dv;

   always #5 clk = ~clk;

   uart_rx_fifo #(.g_Depth(D), .g_Almost_Full(AF)) dut (
      .i_Clk         (clk),
      .i_Rst         (rst),
      .i_RX_DV       (rx_dv),
      .i_RX_Byte     (rx_byte),
      .i_Rd_En       (rd_en),
      .o_Rd_Byte     (rd_byte),
      .o_Rd_DV       (rd_dv),
      .o_Empty       (empty),
      .o_Full        (full),
      .o_Almost_Full (afull),
      .o_Count       (count)
`ifdef UART_RX_FIFO_OVF_EN
      ,
      .i_Ovf_Clr     (ovf_clr),
      .o_Overflow    (overflow)
`endif
   );

   // Drive one cycle of inputs, advance the reference model, sample 1 ns after the edge.
   task automatic cycle(input logic r, input logic dv, input logic [7:0] b,
                        input logic re, input logic clr);
      bit racc, wacc;
      rst = r; rx_dv = dv; rx_byte = b; rd_en = re;
`ifdef UART_RX_FIFO_OVF_EN
      ovf_clr = clr;
`endif
      @(posedge clk);
      if (r) begin
         q.delete();
         exp_dv = 0;
         exp_byte = 8'h00;
`ifdef UART_RX_FIFO_OVF_EN
         exp_ovf = 0;
`endif
      end else begin
         racc = re && (q.size() != 0);
         wacc = dv && ((q.size() < D) || racc);
         exp_dv = racc;
         if (racc) exp_byte = q.pop_front();
         if (wacc) q.push_back(b);
`ifdef UART_RX_FIFO_OVF_EN
         if (dv && !wacc) exp_ovf = 1;
         else if (clr)    exp_ovf = 0;
`endif
      end
      #1;
   endtask

   task automatic test_reset();
      cycle(1, 1, 8'hEE, 1, 0);
      cycle(1, 0, 8'h00, 0, 0);
      n_tot++; if (count !== 5'd0) $display("FAIL reset_count: got %0d exp 0", count); else n_pass++;
      n_tot++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b exp 1", empty); else n_pass++;
      n_tot++; if (full !== 1'b0 || afull !== 1'b0) $display("FAIL reset_full_af: got %b%b exp 00", full, afull); else n_pass++;
      n_tot++; if (rd_dv !== 1'b0 || rd_byte !== 8'h00) $display("FAIL reset_rd: got dv=%b byte=%h exp 0/00", rd_dv, rd_byte); else n_pass++;
`ifdef UART_RX_FIFO_OVF_EN
      n_tot++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b exp 0", overflow); else n_pass++;
`endif
   endtask

   task automatic test_basic();
      logic [7:0] vals [3];
      vals = '{8'h11, 8'h22, 8'h33};
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, vals[i], 0, 0);
      n_tot++; if (count !== 5'd3) $display("FAIL basic_count3: got %0d exp 3", count); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 1, 0);
         n_tot++; if (rd_dv !== 1'b1 || rd_byte !== vals[i])
            $display("FAIL basic_read%0d: got dv=%b byte=%h exp 1/%h", i, rd_dv, rd_byte, vals[i]); else n_pass++;
         n_tot++; if (count !== 5'(2 - i)) $display("FAIL basic_count: got %0d exp %0d", count, 2 - i); else n_pass++;
      end
      cycle(0, 0, 0, 0, 0);
      n_tot++; if (rd_dv !== 1'b0 || empty !== 1'b1 || rd_byte !== 8'h33)
         $display("FAIL basic_end: got dv=%b empty=%b byte=%h exp 0/1/33", rd_dv, empty, rd_byte); else n_pass++;
   endtask

   task automatic test_full();
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i <= 16; i++) begin
         cycle(0, 1, 8'(i), 0, 0);
         if (i == 14) begin
            n_tot++; if (full !== 1'b0) $display("FAIL full_early: got %b exp 0", full); else n_pass++;
         end
         if (i == 15) begin
            n_tot++; if (full !== 1'b1) $display("FAIL full_at16: got %b exp 1", full); else n_pass++;
         end
      end
      n_tot++; if (count !== 5'd16 || full !== 1'b1) $display("FAIL full_drop: got count=%0d full=%b exp 16/1", count, full); else n_pass++;
`ifdef UART_RX_FIFO_OVF_EN
      n_tot++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b exp 1", overflow); else n_pass++;
      cycle(0, 1, 8'h99, 0, 1);
      n_tot++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins: got %b exp 1", overflow); else n_pass++;
      cycle(0, 0, 0, 0, 1);
      n_tot++; if (overflow !== 1'b0) $display("FAIL ovf_clr: got %b exp 0", overflow); else n_pass++;
`endif
      // Full plus simultaneous write and read: head out, AA in at the tail.
      cycle(0, 1, 8'hAA, 1, 0);
      n_tot++; if (rd_dv !== 1'b1 || rd_byte !== 8'h00) $display("FAIL fullrw_head: got dv=%b byte=%h exp 1/00", rd_dv, rd_byte); else n_pass++;
      n_tot++; if (count !== 5'd16 || full !== 1'b1) $display("FAIL fullrw_count: got %0d full=%b exp 16/1", count, full); else n_pass++;
`ifdef UART_RX_FIFO_OVF_EN
      n_tot++; if (overflow !== 1'b0) $display("FAIL fullrw_ovf: got %b exp 0", overflow); else n_pass++;
`endif
      for (int i = 1; i <= 16; i++) begin
         logic [7:0] e;
         e = (i == 16) ? 8'hAA : 8'(i);
         cycle(0, 0, 0, 1, 0);
         n_tot++; if (rd_dv !== 1'b1 || rd_byte !== e) $display("FAIL full_drain%0d: got dv=%b byte=%h exp 1/%h", i, rd_dv, rd_byte, e); else n_pass++;
      end
      n_tot++; if (empty !== 1'b1 || count !== 5'd0) $display("FAIL full_empty: got empty=%b count=%0d exp 1/0", empty, count); else n_pass++;
   endtask

   task automatic test_empty_rw();
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 8'h5A, 1, 0);
      n_tot++; if (rd_dv !== 1'b0) $display("FAIL emptyrw_dv: got %b exp 0", rd_dv); else n_pass++;
      n_tot++; if (count !== 5'd1 || empty !== 1'b0) $display("FAIL emptyrw_count: got %0d empty=%b exp 1/0", count, empty); else n_pass++;
      cycle(0, 0, 0, 1, 0);
      n_tot++; if (rd_dv !== 1'b1 || rd_byte !== 8'h5A) $display("FAIL emptyrw_read: got dv=%b byte=%h exp 1/5a", rd_dv, rd_byte); else n_pass++;
      cycle(0, 0, 0, 1, 0);
      n_tot++; if (rd_dv !== 1'b0 || rd_byte !== 8'h5A) $display("FAIL emptyrw_hold: got dv=%b byte=%h exp 0/5a", rd_dv, rd_byte); else n_pass++;
   endtask

   task automatic test_wrap();
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) begin
         cycle(0, 1, 8'($urandom), 0, 0);
         n_tot++; if (afull !== (i + 1 >= AF) || count !== 5'(i + 1))
            $display("FAIL wrap_af%0d: got af=%b count=%0d exp %b/%0d", i, afull, count, i + 1 >= AF, i + 1); else n_pass++;
      end
      for (int i = 0; i < 32; i++) begin
         bit rd;
         rd = (i < 12) ? 1'b1 : ((i - 12) % 2 == 1);
         cycle(0, i >= 12, 8'($urandom), rd, 0);
         n_tot++; if (count !== 5'(q.size()) || afull !== (q.size() >= AF))
            $display("FAIL wrap_count%0d: got %0d af=%b exp %0d/%b", i, count, afull, q.size(), q.size() >= AF); else n_pass++;
         n_tot++; if (rd_dv !== exp_dv || (exp_dv && rd_byte !== exp_byte))
            $display("FAIL wrap_data%0d: got dv=%b byte=%h exp %b/%h", i, rd_dv, rd_byte, exp_dv, exp_byte); else n_pass++;
      end
      while (q.size() != 0) begin
         cycle(0, 0, 0, 1, 0);
         n_tot++; if (rd_dv !== 1'b1 || rd_byte !== exp_byte) $display("FAIL wrap_drain: got dv=%b byte=%h exp 1/%h", rd_dv, rd_byte, exp_byte); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 1, 8'(8'h40 + i), 0, 0);
      cycle(0, 0, 0, 1, 0);
      cycle(1, 1, 8'h77, 1, 0);
      n_tot++; if (count !== 5'd0 || empty !== 1'b1 || rd_dv !== 1'b0 || rd_byte !== 8'h00)
         $display("FAIL rstmid: got count=%0d empty=%b dv=%b byte=%h exp 0/1/0/00", count, empty, rd_dv, rd_byte); else n_pass++;
      cycle(0, 0, 0, 1, 0);
      n_tot++; if (rd_dv !== 1'b0 || count !== 5'd0) $display("FAIL rstmid_read: got dv=%b count=%0d exp 0/0", rd_dv, count); else n_pass++;
   endtask

   task automatic test_random();
      cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
         bit dv, re, r, clr;
         // Phases bias toward filling, then draining, then balanced traffic.
         dv  = (i < 200) ? ($urandom_range(3) != 0) : (i < 400) ? ($urandom_range(3) == 0) : $urandom_range(1);
         re  = (i < 200) ? ($urandom_range(3) == 0) : (i < 400) ? ($urandom_range(3) != 0) : $urandom_range(1);
         r   = ($urandom_range(99) == 0);
         clr = ($urandom_range(7) == 0);
         cycle(r, dv, 8'($urandom), re, clr);
         n_tot++; if (count !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == D) || afull !== (q.size() >= AF))
            $display("FAIL rand_status%0d: got c=%0d e=%b f=%b af=%b exp c=%0d", i, count, empty, full, afull, q.size()); else n_pass++;
         n_tot++; if (rd_dv !== exp_dv || rd_byte !== exp_byte)
            $display("FAIL rand_data%0d: got dv=%b byte=%h exp %b/%h", i, rd_dv, rd_byte, exp_dv, exp_byte); else n_pass++;
`ifdef UART_RX_FIFO_OVF_EN
         n_tot++; if (overflow !== exp_ovf) $display("FAIL rand_ovf%0d: got %b exp %b", i, overflow, exp_ovf); else n_pass++;
`endif
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_empty_rw();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
